// File: rtl/calc_pkg.sv
// Shared key codes, FSM states and WAIT length for the calculator sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_EQ  = 4'd11;
  localparam logic [3:0] KEY_CLR = 4'd12;

  // Cycles spent in WAIT while the adder's registered sum settles.
  localparam int WAIT_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER_A,
    ST_ENTER_B,
    ST_WAIT,
    ST_SHOW
  } state_t;

  // Codes 0..9 are decimal digits.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Two-digit BCD operand register with entered-digit count (0..2).
// Latency: clr/load/shift visible one cycle after the sampling edge.
// Backpressure: none; caller gates shift when the operand is full.
module bcd_entry_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] digit,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] count
);

  // Clear wins over load; load restarts the operand with a single digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= 4'd0;
      ones  <= 4'd0;
      count <= 2'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      ones  <= 4'd0;
      count <= 2'd0;
    end else if (load) begin
      tens  <= 4'd0;
      ones  <= digit;
      count <= 2'd1;
    end else if (shift) begin
      tens  <= ones;
      ones  <= digit;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer feeding a registered two-digit BCD adder and a 4-digit display.
// Latency: stores/state 1 cycle after key; display 1 cycle later; sum shown 3 cycles after '='.
// Backpressure: none; keys arriving during WAIT (including clear) are dropped.
module calc_seq_ctrl
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [3:0] add_a0,
  input  logic [3:0] add_a1,
  input  logic [3:0] add_a2,
  input  logic [3:0] add_a3,
  output logic [3:0] store_s0,
  output logic [3:0] store_s1,
  output logic [3:0] store_s2,
  output logic [3:0] store_s3,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic       result_valid,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  logic       a_clr, a_load, a_shift, b_clr, b_shift, capture, res_clr;
  logic [1:0] a_cnt, b_cnt;
  logic [3:0] res0, res1, res2, res3;
  logic       k_dig, k_add, k_eq, k_clr;

  assign k_dig = key_valid && is_digit(key_code);
  assign k_add = key_valid && (key_code == KEY_ADD);
  assign k_eq  = key_valid && (key_code == KEY_EQ);
  assign k_clr = key_valid && (key_code == KEY_CLR);

  bcd_entry_reg u_op_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (a_clr),
    .load  (a_load),
    .shift (a_shift),
    .digit (key_code),
    .tens  (store_s3),
    .ones  (store_s2),
    .count (a_cnt)
  );

  bcd_entry_reg u_op_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (b_clr),
    .load  (1'b0),
    .shift (b_shift),
    .digit (key_code),
    .tens  (store_s1),
    .ones  (store_s0),
    .count (b_cnt)
  );

  // State and WAIT counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Key decode per state; operands hold untouched through WAIT and SHOW.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    a_clr        = 1'b0;
    a_load       = 1'b0;
    a_shift      = 1'b0;
    b_clr        = 1'b0;
    b_shift      = 1'b0;
    capture      = 1'b0;
    res_clr      = 1'b0;
    if (k_clr && state != ST_WAIT) begin
      state_nxt    = ST_IDLE;
      wait_cnt_nxt = 2'd0;
      a_clr        = 1'b1;
      b_clr        = 1'b1;
      res_clr      = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (k_dig) begin
            a_load    = 1'b1;
            state_nxt = ST_ENTER_A;
          end else if (k_add) begin
            a_clr     = 1'b1;
            b_clr     = 1'b1;
            state_nxt = ST_ENTER_B;
          end
        end
        ST_ENTER_A: begin
          if (k_dig) begin
            a_shift = (a_cnt != 2'd2);
          end else if (k_add) begin
            b_clr     = 1'b1;
            state_nxt = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (k_dig) begin
            b_shift = (b_cnt != 2'd2);
          end else if (k_eq) begin
            wait_cnt_nxt = 2'd0;
            state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'(WAIT_CYCLES - 1)) begin
            capture      = 1'b1;
            wait_cnt_nxt = 2'd0;
            state_nxt    = ST_SHOW;
          end else begin
            wait_cnt_nxt = wait_cnt + 2'd1;
          end
        end
        ST_SHOW: begin
          if (k_dig) begin
            a_load    = 1'b1;
            b_clr     = 1'b1;
            state_nxt = ST_ENTER_A;
          end else if (k_add) begin
            b_clr     = 1'b1;
            state_nxt = ST_ENTER_B;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Result registers: captured from the adder on the WAIT->SHOW edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {res3, res2, res1, res0} <= 16'd0;
    end else if (res_clr) begin
      {res3, res2, res1, res0} <= 16'd0;
    end else if (capture) begin
      {res3, res2, res1, res0} <= {add_a3, add_a2, add_a1, add_a0};
    end
  end

  // Registered display mux, one cycle behind the stores; frozen during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {disp3, disp2, disp1, disp0} <= 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_ENTER_A: {disp3, disp2, disp1, disp0} <= {8'd0, store_s3, store_s2};
        ST_ENTER_B:          {disp3, disp2, disp1, disp0} <= {8'd0, store_s1, store_s0};
        ST_SHOW:             {disp3, disp2, disp1, disp0} <= {res3, res2, res1, res0};
        default: ;
      endcase
    end
  end

  assign busy         = (state == ST_WAIT);
  assign result_valid = (state == ST_SHOW);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed test-plan sequences plus random key traffic.
// Latency: checks every output #1 after each rising edge against a value-level model.
// Backpressure: n/a.
module tb_calc_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] add_a0, add_a1, add_a2, add_a3;
  logic [3:0] store_s0, store_s1, store_s2, store_s3;
  logic [3:0] disp0, disp1, disp2, disp3;
  logic       result_valid;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  calc_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .add_a0       (add_a0),
    .add_a1       (add_a1),
    .add_a2       (add_a2),
    .add_a3       (add_a3),
    .store_s0     (store_s0),
    .store_s1     (store_s1),
    .store_s2     (store_s2),
    .store_s3     (store_s3),
    .disp0        (disp0),
    .disp1        (disp1),
    .disp2        (disp2),
    .disp3        (disp3),
    .result_valid (result_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: registered decimal sum of the two presented operands.
  int add_sum = 0;
  always @(posedge clk)
    add_sum <= 10 * int'(store_s3) + int'(store_s2) + 10 * int'(store_s1) + int'(store_s0);
  assign add_a0 = 4'(add_sum % 10);
  assign add_a1 = 4'((add_sum / 10) % 10);
  assign add_a2 = 4'((add_sum / 100) % 10);
  assign add_a3 = 4'(add_sum / 1000);

  // Reference model, kept as plain decimal values.
  // ph: 0 idle, 1 entering A, 2 entering B, 3 waiting, 4 showing.
  int m_ph, m_a, m_b, m_an, m_bn, m_wait, m_res, m_disp;

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_b = 0; m_an = 0; m_bn = 0; m_wait = 0; m_res = 0; m_disp = 0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] c);
    int code;
    code = int'(c);
    if (m_ph == 0 || m_ph == 1) m_disp = m_a;
    else if (m_ph == 2)         m_disp = m_b;
    else if (m_ph == 4)         m_disp = m_res;
    if (m_ph == 3) begin
      m_wait = m_wait + 1;
      if (m_wait == 2) begin
        m_ph  = 4;
        m_res = m_a + m_b;
      end
    end else if (v && code == 12) begin
      m_ph = 0; m_a = 0; m_b = 0; m_an = 0; m_bn = 0; m_res = 0;
    end else if (v && code <= 9) begin
      if (m_ph == 0 || m_ph == 4) begin
        m_a = code; m_an = 1; m_b = 0; m_bn = 0; m_ph = 1;
      end else if (m_ph == 1 && m_an < 2) begin
        m_a = (m_a % 10) * 10 + code; m_an = m_an + 1;
      end else if (m_ph == 2 && m_bn < 2) begin
        m_b = (m_b % 10) * 10 + code; m_bn = m_bn + 1;
      end
    end else if (v && code == 10) begin
      if (m_ph == 0) begin
        m_a = 0; m_an = 0;
      end
      if (m_ph != 2) begin
        m_b = 0; m_bn = 0; m_ph = 2;
      end
    end else if (v && code == 11 && m_ph == 2) begin
      m_ph = 3; m_wait = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("stores", {store_s3, store_s2, store_s1, store_s0},
        {4'(m_a / 10), 4'(m_a % 10), 4'(m_b / 10), 4'(m_b % 10)});
    chk("disp", {disp3, disp2, disp1, disp0}, bcd4(m_disp));
    chk("busy", 16'(busy), 16'(m_ph == 3));
    chk("result_valid", 16'(result_valid), 16'(m_ph == 4));
  endtask

  task automatic tick(input logic v, input logic [3:0] c);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    check_model();
  endtask

  task automatic press_seq(input logic [3:0] keys[$]);
    foreach (keys[i]) tick(1'b1, keys[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h0000);
    chk("reset_disp", {disp3, disp2, disp1, disp0}, 16'h0000);
    chk("reset_flags", {14'd0, busy, result_valid}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 12 + 34
    press_seq('{4'd1, 4'd2, 4'd10, 4'd3, 4'd4, 4'd11});
    chk("tp1_busy_c1", 16'(busy), 16'h1);
    chk("tp1_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h1234);
    idle(1);
    chk("tp1_busy_c2", 16'(busy), 16'h1);
    idle(1);
    chk("tp1_busy_off", 16'(busy), 16'h0);
    chk("tp1_rv", 16'(result_valid), 16'h1);
    idle(1);
    chk("tp1_disp", {disp3, disp2, disp1, disp0}, 16'h0046);

    // 99 + 99, started straight from SHOW
    press_seq('{4'd9, 4'd9, 4'd10, 4'd9, 4'd9, 4'd11});
    idle(3);
    chk("tp2_disp", {disp3, disp2, disp1, disp0}, 16'h0198);

    // 5 + 7
    press_seq('{4'd12, 4'd5, 4'd10, 4'd7, 4'd11});
    chk("tp3_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h0507);
    idle(3);
    chk("tp3_disp", {disp3, disp2, disp1, disp0}, 16'h0012);

    // third digit ignored, then clear
    press_seq('{4'd4, 4'd5, 4'd6});
    chk("tp4_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h4500);
    press_seq('{4'd12});
    idle(1);
    chk("tp4_clr_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h0000);
    chk("tp4_clr_disp", {disp3, disp2, disp1, disp0}, 16'h0000);

    // clear during WAIT is dropped
    press_seq('{4'd2, 4'd10, 4'd3, 4'd11, 4'd12});
    idle(2);
    chk("tp5_disp", {disp3, disp2, disp1, disp0}, 16'h0005);
    press_seq('{4'd8});
    chk("tp5_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h0800);
    chk("tp5_rv", 16'(result_valid), 16'h0);
    idle(1);
    chk("tp5_disp8", {disp3, disp2, disp1, disp0}, 16'h0008);

    // reset asserted mid-WAIT
    press_seq('{4'd12, 4'd1, 4'd10, 4'd1, 4'd11});
    idle(1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("tp6_stores", {store_s3, store_s2, store_s1, store_s0}, 16'h0000);
    chk("tp6_disp", {disp3, disp2, disp1, disp0}, 16'h0000);
    chk("tp6_flags", {14'd0, busy, result_valid}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("tp6_no_result", 16'(result_valid), 16'h0);

    // random key traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(0, 19));
      if (r < 12)      c = 4'(r % 10);
      else if (r < 15) c = 4'd10;
      else if (r < 17) c = 4'd11;
      else if (r < 18) c = 4'd12;
      else             c = 4'($urandom_range(13, 15));
      tick($urandom_range(0, 3) != 0, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
